// File: rtl/word_bank_loader_pkg.sv
// rtl/word_bank_loader_pkg.sv - shared state type and width helpers for the word bank loader
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } loader_state_e;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of an index into a depth-entry bank; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/word_bank.sv
// rtl/word_bank.sv - DEPTH x WIDTH register bank, one write port, combinational read with range guard
module word_bank
    import loader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_in_range;
    logic             rd_in_range;

    // One extra bit so DEPTH itself is representable even when it is a power of two.
    assign wr_in_range = {1'b0, waddr} < (AW + 1)'(DEPTH);
    assign rd_in_range = {1'b0, raddr} < (AW + 1)'(DEPTH);

    // Bank storage: cleared on reset, otherwise written one word per accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && wr_in_range) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = rd_in_range ? mem_q[raddr] : '0;

endmodule

// File: rtl/word_bank_loader.sv
// rtl/word_bank_loader.sv - fills a word bank from a valid/ready stream, locks when full, re-armable
module word_bank_loader
    import loader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       rearm,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       done,
    output logic                       overflow,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data
);

    localparam int CW = count_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    loader_state_e   state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            accept;
    logic            bank_we;
    logic [AW-1:0]   bank_waddr;

    // Rearm blocks acceptance in its own cycle so no word can slip in and be discarded.
    assign in_ready   = (state_q != DONE) && !rearm;
    assign accept     = in_valid && in_ready;
    assign bank_waddr = count_q[AW-1:0];

    // Next-state, count and overflow decode; rearm overrides every state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        bank_we    = 1'b0;
        if (rearm) begin
            state_d    = IDLE;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bank_we = 1'b1;
                        count_d = CW'(1);
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        bank_we = 1'b1;
                        count_d = count_q + CW'(1);
                        if (count_q == CW'(DEPTH - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (in_valid) begin
                        overflow_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign done     = (state_q == DONE);
    assign count    = count_q;
    assign overflow = overflow_q;

    word_bank #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .we   (bank_we),
        .waddr(bank_waddr),
        .wdata(in_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_word_bank_loader.sv
// tb/tb_word_bank_loader.sv - directed self-checking bench for word_bank_loader
module tb_word_bank_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rearm;
    logic [2:0] count;
    logic       done;
    logic       overflow;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       b_rearm;
    logic [1:0] b_count;
    logic       b_done;
    logic       b_overflow;
    logic [1:0] b_rd_addr;
    logic [7:0] b_rd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    word_bank_loader #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rearm(rearm), .count(count), .done(done),
        .overflow(overflow), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    word_bank_loader #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .rearm(b_rearm), .count(b_count), .done(b_done),
        .overflow(b_overflow), .rd_addr(b_rd_addr), .rd_data(b_rd_data)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_w [4];
        exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk_eq($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(exp_w[a]));
        end
    endtask

    logic [7:0] load_a [4];
    logic [7:0] load_b [4];

    initial begin
        load_a[0] = 8'h11; load_a[1] = 8'h22; load_a[2] = 8'h33; load_a[3] = 8'h44;
        load_b[0] = 8'h55; load_b[1] = 8'h66; load_b[2] = 8'h77; load_b[3] = 8'h88;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; rearm = 1'b0; rd_addr = '0;
        b_valid = 1'b0; b_data = '0; b_rearm = 1'b0; b_rd_addr = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
        chk_eq("rst_count",    32'(count),    32'd0);
        chk_eq("rst_done",     32'(done),     32'd0);
        chk_eq("rst_overflow", 32'(overflow), 32'd0);
        check_bank("rst", 8'h00, 8'h00, 8'h00, 8'h00);

        // Back-to-back load
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = load_a[i];
            tick();
            chk_eq($sformatf("b2b_count%0d", i), 32'(count), 32'(i + 1));
            if (i < 3) chk_eq($sformatf("b2b_done%0d", i), 32'(done), 32'd0);
        end
        in_valid = 1'b0;
        #1;
        chk_eq("b2b_done",     32'(done),     32'd1);
        chk_eq("b2b_in_ready", 32'(in_ready), 32'd0);
        check_bank("b2b", 8'h11, 8'h22, 8'h33, 8'h44);

        // Write attempt while locked
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        chk_eq("ovf_in_ready", 32'(in_ready), 32'd0);
        chk_eq("ovf_pre",      32'(overflow), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk_eq("ovf_set",   32'(overflow), 32'd1);
        chk_eq("ovf_count", 32'(count),    32'd4);
        check_bank("ovf", 8'h11, 8'h22, 8'h33, 8'h44);
        tick();
        chk_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Rearm with a simultaneous valid word: word must not be taken
        rearm    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        chk_eq("rearm_in_ready", 32'(in_ready), 32'd0);
        tick();
        rearm    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_eq("rearm_count",    32'(count),    32'd0);
        chk_eq("rearm_done",     32'(done),     32'd0);
        chk_eq("rearm_overflow", 32'(overflow), 32'd0);
        chk_eq("rearm_ready",    32'(in_ready), 32'd1);
        rd_addr = 2'd0;
        #1;
        chk_eq("rearm_keep0", 32'(rd_data), 32'h11);

        // Gapped load of the second set
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = (i % 2 == 0) ? load_b[i / 2] : 8'hEE;
            tick();
            chk_eq($sformatf("gap_count%0d", i), 32'(count), 32'(i / 2 + 1));
        end
        in_valid = 1'b0;
        #1;
        chk_eq("gap_done", 32'(done), 32'd1);
        check_bank("gap", 8'h55, 8'h66, 8'h77, 8'h88);

        // Reset in the middle of a load
        rearm = 1'b1;
        tick();
        rearm    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        in_data  = 8'hAB;
        tick();
        in_valid = 1'b0;
        #1;
        chk_eq("mid_count", 32'(count), 32'd2);
        check_bank("mid", 8'h99, 8'hAB, 8'h77, 8'h88);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk_eq("mrst_count",    32'(count),    32'd0);
        chk_eq("mrst_done",     32'(done),     32'd0);
        chk_eq("mrst_in_ready", 32'(in_ready), 32'd1);
        check_bank("mrst", 8'h00, 8'h00, 8'h00, 8'h00);

        // DEPTH=3 build: fill then probe past the end
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1;
            b_data  = 8'hC1 + 8'(i);
            tick();
        end
        b_valid = 1'b0;
        #1;
        chk_eq("d3_done",  32'(b_done),  32'd1);
        chk_eq("d3_count", 32'(b_count), 32'd3);
        b_rd_addr = 2'd2;
        #1;
        chk_eq("d3_rd2", 32'(b_rd_data), 32'hC3);
        b_rd_addr = 2'd3;
        #1;
        chk_eq("d3_rd_oob", 32'(b_rd_data), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
